// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding and STATUS byte layout for the SPI command sequencer.
package spi_cmd_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE  = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ   = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_STATUS = 8'h03;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CMD         = 3'd1,
    ADDR        = 3'd2,
    WDATA       = 3'd3,
    RADDR_ISSUE = 3'd4,
    RDATA       = 3'd5,
    DISCARD     = 3'd6
  } state_e;

  // STATUS reply: sticky error in the MSB, last legal opcode in the low nibble
  typedef struct packed {
    logic       err;
    logic [2:0] rsvd;
    logic [3:0] last_cmd;
  } status_t;

  function automatic logic [BYTE_W-1:0] status_byte(input logic err, input logic [3:0] last_cmd);
    status_t s;
    s.err      = err;
    s.rsvd     = 3'b000;
    s.last_cmd = last_cmd;
    return s;
  endfunction

endpackage

// File: rtl/spi_cmd_addr_ctr.sv
// Loadable wrapping register-address counter; increments only when SPI_CMD_AUTOINC_EN is defined,
// otherwise the address stays fixed for the frame (FIFO-style port).
module spi_cmd_addr_ctr
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

`ifdef SPI_CMD_AUTOINC_EN
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end
`else
  logic unused_inc;
  assign unused_inc = inc_i;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI frame command sequencer: parses [cmd][addr][data...] into register-bus writes and burst reads.
// Optional address auto-increment is selected with SPI_CMD_AUTOINC_EN (see spi_cmd_addr_ctr).
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [BYTE_W-1:0] STATUS_ID = 8'hA5
) (
  input  logic              ico_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              tx_load,
  output logic [BYTE_W-1:0] tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              err,
  output logic              activity
);

  state_e            state_q, state_d;
  logic              is_read_q, is_read_d;
  logic [3:0]        last_cmd_q, last_cmd_d;
  logic              err_q, err_d;
  logic              tx_load_q, tx_load_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              activity_q, activity_d;
  logic              rd_cap_q, rd_cap_d;

  logic              ctr_load;
  logic              ctr_inc;
  logic [ADDR_W-1:0] addr;

  spi_cmd_addr_ctr #(
    .ADDR_W(ADDR_W)
  ) u_addr_ctr (
    .clk_i     (ico_clk),
    .rst_n_i   (rst_n),
    .load_i    (ctr_load),
    .load_val_i(rx_data[ADDR_W-1:0]),
    .inc_i     (ctr_inc),
    .addr_o    (addr)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    last_cmd_d  = last_cmd_q;
    err_d       = err_q;
    tx_load_d   = 1'b0;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    activity_d  = 1'b0;
    rd_cap_d    = reg_re_q;
    ctr_load    = 1'b0;
    ctr_inc     = 1'b0;

    // reg_rdata is valid the cycle after reg_re; this completes even after frame_end
    if (rd_cap_q) begin
      tx_data_d  = reg_rdata;
      tx_load_d  = 1'b1;
      activity_d = 1'b1;
    end

    unique case (state_q)
      IDLE: ;
      CMD: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE, CMD_READ: begin
              state_d    = ADDR;
              is_read_d  = (rx_data == CMD_READ);
              last_cmd_d = rx_data[3:0];
            end
            CMD_STATUS: begin
              state_d    = DISCARD;
              tx_data_d  = status_byte(err_q, last_cmd_q);
              tx_load_d  = 1'b1;
              last_cmd_d = rx_data[3:0];
            end
            default: begin
              state_d = DISCARD;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ADDR: begin
        if (rx_valid) begin
          ctr_load = 1'b1;
          state_d  = is_read_q ? RADDR_ISSUE : WDATA;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = addr;
          reg_wdata_d = rx_data;
          activity_d  = 1'b1;
          ctr_inc     = 1'b1;
        end
      end
      RADDR_ISSUE: begin
        reg_re_d   = 1'b1;
        reg_addr_d = addr;
        ctr_inc    = 1'b1;
        state_d    = RDATA;
      end
      RDATA: begin
        if (rx_valid) begin
          state_d = RADDR_ISSUE;
        end
      end
      DISCARD: ;
      default: state_d = IDLE;
    endcase

    // A byte arriving with frame_end has already been handled above
    if (frame_end) begin
      state_d = IDLE;
    end

    if (frame_start) begin
      if (state_q != IDLE) begin
        err_d = 1'b1;
      end
      state_d   = CMD;
      tx_data_d = STATUS_ID;
      tx_load_d = 1'b1;
    end
  end

  always_ff @(posedge ico_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_read_q   <= 1'b0;
      last_cmd_q  <= 4'h0;
      err_q       <= 1'b0;
      tx_load_q   <= 1'b0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      activity_q  <= 1'b0;
      rd_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      last_cmd_q  <= last_cmd_d;
      err_q       <= err_d;
      tx_load_q   <= tx_load_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      activity_q  <= activity_d;
      rd_cap_q    <= rd_cap_d;
    end
  end

  assign tx_load   = tx_load_q;
  assign tx_data   = tx_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign err       = err_q;
  assign activity  = activity_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       ico_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] reg_rdata = 8'h00;
  logic       tx_load, reg_we, reg_re, err, activity;
  logic [7:0] tx_data, reg_addr, reg_wdata;

  int total = 0;
  int bad = 0;

  always #5 ico_clk = ~ico_clk;

  spi_cmd_ctrl #(
    .ADDR_W   (8),
    .STATUS_ID(8'hA5)
  ) dut (
    .ico_clk    (ico_clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .err        (err),
    .activity   (activity)
  );

  // Register space: every register reads back as its address plus one
  always @(posedge ico_clk) if (reg_re) reg_rdata <= reg_addr + 8'd1;

  // Observed bus activity (written only here)
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  time         tx_t_q[$];
  int          act_cnt = 0;
  int          overlap = 0;

  always @(negedge ico_clk) begin
    if (reg_we) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_re) rd_q.push_back(reg_addr);
    if (tx_load) begin
      tx_q.push_back(tx_data);
      tx_t_q.push_back($time);
    end
    if (activity) act_cnt++;
    if (reg_we && reg_re) overlap++;
  end

  // Expected activity and model state (written only by the stimulus process)
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          exp_act;
  bit          m_err;
  logic [3:0]  m_last;
  logic [7:0]  fb[$];
  time         byte_t[$];
  int          wb, rb, tb, ab, ob, bb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fb(input int n, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    fb.delete();
    if (n > 0) fb.push_back(a);
    if (n > 1) fb.push_back(b);
    if (n > 2) fb.push_back(c);
    if (n > 3) fb.push_back(d);
  endtask

  task automatic begin_frame();
    wb = wr_q.size(); rb = rd_q.size(); tb = tx_q.size();
    ab = act_cnt; ob = overlap; bb = byte_t.size();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_act = 0;
  endtask

  // Frame-level reference: what one SEL frame carrying fb should produce on the bus
  task automatic model_frame();
    logic [7:0] a;
    exp_tx.push_back(8'hA5);
    if (fb.size() == 0) return;
    case (fb[0])
      8'h01: begin
        m_last = 4'h1;
        if (fb.size() >= 2) begin
          a = fb[1];
          for (int i = 2; i < fb.size(); i++) begin
            exp_wr.push_back({a, fb[i]});
            exp_act++;
            if (AUTOINC) a = a + 8'd1;
          end
        end
      end
      8'h02: begin
        m_last = 4'h2;
        if (fb.size() >= 2) begin
          a = fb[1];
          for (int i = 1; i < fb.size(); i++) begin
            exp_rd.push_back(a);
            exp_tx.push_back(a + 8'd1);
            exp_act++;
            if (AUTOINC) a = a + 8'd1;
          end
        end
      end
      8'h03: begin
        exp_tx.push_back({m_err, 3'b000, m_last});
        m_last = 4'h3;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " wr_n"}, 32'(wr_q.size() - wb), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && wb + i < wr_q.size(); i++)
      chk({tag, " wr"}, 32'(wr_q[wb + i]), 32'(exp_wr[i]));
    chk({tag, " rd_n"}, 32'(rd_q.size() - rb), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && rb + i < rd_q.size(); i++)
      chk({tag, " rd"}, 32'(rd_q[rb + i]), 32'(exp_rd[i]));
    chk({tag, " tx_n"}, 32'(tx_q.size() - tb), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && tb + i < tx_q.size(); i++)
      chk({tag, " tx"}, 32'(tx_q[tb + i]), 32'(exp_tx[i]));
    chk({tag, " act"}, 32'(act_cnt - ab), 32'(exp_act));
    chk({tag, " err"}, 32'(err), 32'(m_err));
    chk({tag, " overlap"}, 32'(overlap - ob), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(6, 10)) @(posedge ico_clk);
    #1 rx_valid = 1'b1; rx_data = b;
    @(posedge ico_clk);
    byte_t.push_back($time);
    #1 rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge ico_clk);
    #1 frame_start = 1'b1;
    @(posedge ico_clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic end_frame();
    repeat (8) @(posedge ico_clk);
    #1 frame_end = 1'b1;
    @(posedge ico_clk);
    #1 frame_end = 1'b0;
    repeat (3) @(posedge ico_clk);
  endtask

  task automatic run_frame(input string tag);
    begin_frame();
    model_frame();
    start_frame();
    foreach (fb[i]) send_byte(fb[i]);
    end_frame();
    check_frame(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    m_err = 1'b0;
    m_last = 4'h0;

    // Reset values
    repeat (3) @(posedge ico_clk);
    @(negedge ico_clk);
    chk("rst strobes", 32'({tx_load, reg_we, reg_re, activity, err}), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'h00);
    chk("rst reg_addr", 32'(reg_addr), 32'h00);
    chk("rst reg_wdata", 32'(reg_wdata), 32'h00);
    @(posedge ico_clk);
    #1 rst_n = 1'b1;

    // Stray byte outside a frame is ignored, then a write burst
    send_byte(8'h02);
    set_fb(4, 8'h01, 8'h10, 8'h5A, 8'hC3);
    run_frame("write");

    // Read burst with address-to-tx_load latency
    set_fb(4, 8'h02, 8'h20, 8'h00, 8'h00);
    run_frame("read");
    if (tx_q.size() > tb + 1 && byte_t.size() > bb + 1)
      chk("read latency", 32'(tx_t_q[tb + 1] - byte_t[bb + 1]), 32'd35);
    else
      chk("read latency present", 32'd0, 32'd1);

    // Last data byte coincides with frame_end
    set_fb(4, 8'h01, 8'h60, 8'h77, 8'h88);
    begin_frame();
    model_frame();
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(fb[i]);
    repeat (7) @(posedge ico_clk);
    #1 rx_valid = 1'b1; rx_data = fb[3]; frame_end = 1'b1;
    @(posedge ico_clk);
    #1 rx_valid = 1'b0; frame_end = 1'b0;
    repeat (4) @(posedge ico_clk);
    check_frame("end_with_byte");
    set_fb(1, 8'h03, 8'h00, 8'h00, 8'h00);
    run_frame("status_after_end");

    // frame_start during WDATA: first write completes, err set, new command accepted
    set_fb(3, 8'h01, 8'h30, 8'h44, 8'h00);
    begin_frame();
    model_frame();
    start_frame();
    foreach (fb[i]) send_byte(fb[i]);
    repeat (4) @(posedge ico_clk);
    m_err = 1'b1;
    set_fb(3, 8'h01, 8'h40, 8'h66, 8'h00);
    model_frame();
    start_frame();
    foreach (fb[i]) send_byte(fb[i]);
    end_frame();
    check_frame("restart");

    // Reset during a burst read
    begin_frame();
    start_frame();
    send_byte(8'h02);
    send_byte(8'h50);
    n = 0;
    while (tx_q.size() - tb < 2 && n < 40) begin
      @(posedge ico_clk);
      n++;
    end
    chk("midrst first read seen", 32'(n < 40), 32'd1);
    if (tx_q.size() > tb + 1) chk("midrst first read data", 32'(tx_q[tb + 1]), 32'h51);
    send_byte(8'h00);
    @(posedge ico_clk);
    #2 rst_n = 1'b0;
    @(negedge ico_clk);
    chk("midrst strobes", 32'({tx_load, reg_we, reg_re, activity, err}), 32'd0);
    chk("midrst tx_data", 32'(tx_data), 32'h00);
    chk("midrst reg_addr", 32'(reg_addr), 32'h00);
    repeat (2) @(posedge ico_clk);
    #1 rst_n = 1'b1;
    m_err = 1'b0;
    m_last = 4'h0;
    set_fb(1, 8'h03, 8'h00, 8'h00, 8'h00);
    run_frame("status_after_reset");

    // Illegal opcode, then STATUS reports err and the last legal opcode
    set_fb(3, 8'h7F, 8'h11, 8'h22, 8'h00);
    run_frame("illegal");
    set_fb(1, 8'h03, 8'h00, 8'h00, 8'h00);
    run_frame("status_err");

    // Address wrap at the top of the register space
    set_fb(4, 8'h01, 8'hFF, 8'h12, 8'h34);
    run_frame("wrap");

    // Random frames
    for (int f = 0; f < 20; f++) begin
      int r;
      int len;
      logic [7:0] c;
      r = $urandom_range(0, 5);
      len = $urandom_range(1, 5);
      case (r)
        0, 1:    c = 8'h01;
        2, 3:    c = 8'h02;
        4:       c = 8'h03;
        default: c = 8'($urandom_range(4, 255));
      endcase
      fb.delete();
      fb.push_back(c);
      for (int i = 1; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
      run_frame($sformatf("rand%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
